gif_sequencer: RTL and testbench

Parametrised animated-image sequencer for the VGA pipeline.
- Selects one of NUM_FRAMES frame ROMs and steps through them at a programmable frame-tick rate.
- Supports loop, ping-pong, one-shot and hold modes, with play/restart control.
- Generates the ROM address for a positioned IMG_W x IMG_H window and returns latency-aligned RGB444 pixels to the VGA mixer.

---
 rtl/gif_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_gif_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gif_sequencer.sv
// gif_sequencer: animated-image sequencer for the VGA pipeline.
// Steps through NUM_FRAMES frame ROMs at a frame-tick derived rate (loop,
// ping-pong, one-shot, hold) and produces a 3-clock pixel pipeline: ROM
// address generation, ROM read, frame-slice select to RGB444.
// Optional build macro COLOR_KEY_EN: adds parameter KEY_COLOR; ROM words
// equal to KEY_COLOR are output as transparent (o_vis=0, RGB=0).
module gif_sequencer #(
  parameter int NUM_FRAMES = 8,
  parameter int FRAME_HOLD = 6,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 12,
  parameter int IDX_W      = 4
`ifdef COLOR_KEY_EN
  ,
  parameter logic [DATA_W-1:0] KEY_COLOR = 12'h0F0
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [10:0]                h_cnt,
  input  logic [10:0]                v_cnt,
  input  logic [10:0]                h_org,
  input  logic [10:0]                v_org,
  input  logic [1:0]                 mode,
  input  logic                       play,
  input  logic                       restart,
  input  logic [NUM_FRAMES*DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0]          data_addr,
  output logic [IDX_W-1:0]           frame_idx,
  output logic                       done,
  output logic                       o_vis,
  output logic [3:0]                 o_r,
  output logic [3:0]                 o_g,
  output logic [3:0]                 o_b
);

  typedef enum logic [1:0] {
    MODE_LOOP    = 2'b00,
    MODE_PP      = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_FRAMES - 1);
  localparam logic [11:0]       W_LIM     = 12'(IMG_W);
  localparam logic [11:0]       H_LIM     = 12'(IMG_H);

  // ---------------------------------------------------------------------
  // Frame tick
  // ---------------------------------------------------------------------
  logic at_origin;
  logic at_origin_q;
  logic tick;

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign tick      = at_origin && !at_origin_q;

  // Previous-cycle origin flag so a stall at (0,0) yields a single tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) at_origin_q <= 1'b0;
    else        at_origin_q <= at_origin;
  end

  // ---------------------------------------------------------------------
  // Animation control
  // ---------------------------------------------------------------------
  mode_t             cur_mode;
  dir_t              dir, dir_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              done_n;

  assign cur_mode = mode_t'(mode);

  // Animation state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir      <= DIR_UP;
      hold_cnt <= '0;
      idx      <= '0;
      done     <= 1'b0;
    end else begin
      dir      <= dir_n;
      hold_cnt <= hold_n;
      idx      <= idx_n;
      done     <= done_n;
    end
  end

  // Next frame index / hold count / direction / done.
  always_comb begin
    idx_n  = idx;
    hold_n = hold_cnt;
    dir_n  = (cur_mode == MODE_PP) ? dir : DIR_UP;
    done_n = done;
    if (restart) begin
      idx_n  = '0;
      hold_n = '0;
      dir_n  = DIR_UP;
      done_n = 1'b0;
    end else if (tick && play && (cur_mode != MODE_HOLD)) begin
      if (hold_cnt == HOLD_LAST) begin
        hold_n = '0;
        case (cur_mode)
          MODE_LOOP: begin
            idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
          MODE_PP: begin
            // Reversal happens on the advance out of an endpoint, so each
            // endpoint frame is shown for exactly one hold period.
            if (NUM_FRAMES > 1) begin
              if (dir == DIR_UP) begin
                if (idx == IDX_LAST) begin
                  dir_n = DIR_DOWN;
                  idx_n = idx - 1'b1;
                end else begin
                  idx_n = idx + 1'b1;
                end
              end else begin
                if (idx == '0) begin
                  dir_n = DIR_UP;
                  idx_n = idx + 1'b1;
                end else begin
                  idx_n = idx - 1'b1;
                end
              end
            end
          end
          MODE_ONESHOT: begin
            if (idx == IDX_LAST) done_n = 1'b1;
            else                 idx_n  = idx + 1'b1;
          end
          default: ;
        endcase
      end else begin
        hold_n = hold_cnt + 1'b1;
      end
    end
  end

  assign frame_idx = idx;

  // ---------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------
  logic [10:0]       dh;
  logic [10:0]       dv;
  logic              in_win;
  logic [ADDR_W-1:0] addr_next;

  assign dh        = h_cnt - h_org;
  assign dv        = v_cnt - v_org;
  assign in_win    = ({1'b0, dh} < W_LIM) && ({1'b0, dv} < H_LIM);
  assign addr_next = ADDR_W'(dv) * ADDR_W'(IMG_W) + ADDR_W'(dh);

  logic             win_a, win_b;
  logic [IDX_W-1:0] idx_a, idx_b;

  // Stage A: window test and ROM address; address holds outside the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_addr <= '0;
      win_a     <= 1'b0;
      idx_a     <= '0;
    end else begin
      if (in_win) data_addr <= addr_next;
      win_a <= in_win;
      idx_a <= idx;
    end
  end

  // Stage B: align window flag and frame index with the ROM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_b <= 1'b0;
      idx_b <= '0;
    end else begin
      win_b <= win_a;
      idx_b <= idx_a;
    end
  end

  logic [DATA_W-1:0] word;
  logic              opaque;

  // Frame slice select using the pipeline-aligned index.
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < NUM_FRAMES; k++) begin
      if (idx_b == IDX_W'(k)) word = rom_data[k*DATA_W +: DATA_W];
    end
`ifdef COLOR_KEY_EN
    opaque = win_b && (word != KEY_COLOR);
`else
    opaque = win_b;
`endif
  end

  // Stage C: registered RGB444 output, blanked outside the image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vis <= 1'b0;
      o_r   <= '0;
      o_g   <= '0;
      o_b   <= '0;
    end else if (opaque) begin
      o_vis <= 1'b1;
      o_r   <= word[11:8];
      o_g   <= word[7:4];
      o_b   <= word[3:0];
    end else begin
      o_vis <= 1'b0;
      o_r   <= '0;
      o_g   <= '0;
      o_b   <= '0;
    end
  end

endmodule

// File: tb/tb_gif_sequencer.sv
// Self-checking bench for gif_sequencer (default build, 4 frames, hold 6).
module tb_gif_sequencer;

  localparam int NF = 4;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [10:0]   h_cnt, v_cnt, h_org, v_org;
  logic [1:0]    mode;
  logic          play, restart;
  logic [NF*DW-1:0] rom_data = '0;
  logic [15:0]   data_addr;
  logic [3:0]    frame_idx;
  logic          done, o_vis;
  logic [3:0]    o_r, o_g, o_b;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [12:0]   pq[$];
  logic [15:0]   addr_exp = '0;
  int unsigned   exp_idx = 0;

  int            sw_h[12] = '{100, 101, 355, 356, 357, 99, 100, 100, 2000, 200, 200, 5};
  int            sw_v[12] = '{50,  50,  51,  51,  51,  51, 49,  305, 60,   306, 300, 5};
  int unsigned   pp_seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

  gif_sequencer #(
    .NUM_FRAMES(NF),
    .FRAME_HOLD(6),
    .IMG_W(256),
    .IMG_H(256),
    .ADDR_W(16),
    .DATA_W(DW),
    .IDX_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .h_org(h_org),
    .v_org(v_org),
    .mode(mode),
    .play(play),
    .restart(restart),
    .rom_data(rom_data),
    .data_addr(data_addr),
    .frame_idx(frame_idx),
    .done(done),
    .o_vis(o_vis),
    .o_r(o_r),
    .o_g(o_g),
    .o_b(o_b)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_word(input int unsigned k, input logic [15:0] a);
    int unsigned v;
    v = 32'(a) * 37 + k * 291 + 5;
    return v[11:0];
  endfunction

  // Synchronous frame ROMs, one clock of read latency.
  always @(posedge clk) begin
    for (int k = 0; k < NF; k++) rom_data[k*DW +: DW] <= rom_word(k, data_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one pixel coordinate; compare the output of the coordinate driven 3 cycles ago.
  task automatic pix(input int h, input int v);
    int dh, dv;
    logic [15:0] a;
    @(negedge clk);
    check_eq("addr", {16'h0, data_addr}, {16'h0, addr_exp});
    if (pq.size() >= 3) check_eq("pix", {19'h0, o_vis, o_r, o_g, o_b}, {19'h0, pq.pop_front()});
    h_cnt = 11'(h);
    v_cnt = 11'(v);
    dh = h - 100;
    dv = v - 50;
    if (dh >= 0 && dh < 256 && dv >= 0 && dv < 256) begin
      a = 16'(dv * 256 + dh);
      addr_exp = a;
      pq.push_back({1'b1, rom_word(exp_idx, a)});
    end else begin
      pq.push_back(13'h0);
    end
  endtask

  task automatic pix_flush();
    while (pq.size() > 0) begin
      @(negedge clk);
      check_eq("pix", {19'h0, o_vis, o_r, o_g, o_b}, {19'h0, pq.pop_front()});
      h_cnt = 11'd5;
      v_cnt = 11'd5;
    end
  endtask

  task automatic sweep(input int unsigned idx);
    exp_idx = idx;
    for (int i = 0; i < 12; i++) pix(sw_h[i], sw_v[i]);
    pix_flush();
  endtask

  task automatic tick(input int stall);
    @(negedge clk);
    h_cnt = 11'd0;
    v_cnt = 11'd0;
    repeat (stall) @(negedge clk);
    @(negedge clk);
    h_cnt = 11'd5;
    v_cnt = 11'd5;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(0);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; h_cnt = 11'd5; v_cnt = 11'd5; h_org = 11'd100; v_org = 11'd50;
    mode = 2'b00; play = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_addr", {16'h0, data_addr}, 32'h0);
    check_eq("rst_idx", {28'h0, frame_idx}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_out", {19'h0, o_vis, o_r, o_g, o_b}, 32'h0);
    rst_n = 1'b1;

    sweep(0);

    // Reset in the middle of play with a visible pixel on the outputs.
    play = 1'b1;
    ticks(8);
    check_eq("pre_rst_idx", {28'h0, frame_idx}, 32'd1);
    @(negedge clk);
    h_cnt = 11'd101; v_cnt = 11'd50;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_vis", {31'h0, o_vis}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_addr", {16'h0, data_addr}, 32'h0);
    check_eq("mid_rst_idx", {28'h0, frame_idx}, 32'h0);
    check_eq("mid_rst_out", {19'h0, o_vis, o_r, o_g, o_b}, 32'h0);
    addr_exp = '0;
    @(negedge clk);
    h_cnt = 11'd5; v_cnt = 11'd5;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Loop mode, one tick stretched over a 3-cycle stall at the origin.
    mode = 2'b00;
    for (int i = 1; i <= 30; i++) begin
      tick(i == 3 ? 2 : 0);
      check_eq("loop_idx", {28'h0, frame_idx}, 32'((i / 6) % 4));
    end

    play = 1'b0;
    sweep(1);

    // Ping-pong.
    pulse_restart();
    check_eq("rst_pulse_idx", {28'h0, frame_idx}, 32'd0);
    mode = 2'b01; play = 1'b1;
    for (int i = 1; i <= 42; i++) begin
      tick(0);
      check_eq("pp_idx", {28'h0, frame_idx}, 32'(pp_seq[i / 6]));
    end
    ticks(5);
    @(negedge clk);
    h_cnt = 11'd0; v_cnt = 11'd0; restart = 1'b1;
    @(negedge clk);
    h_cnt = 11'd5; v_cnt = 11'd5; restart = 1'b0;
    check_eq("restart_tick_idx", {28'h0, frame_idx}, 32'd0);
    ticks(5);
    check_eq("restart_hold_idx", {28'h0, frame_idx}, 32'd0);
    ticks(1);
    check_eq("restart_adv_idx", {28'h0, frame_idx}, 32'd1);

    // One-shot.
    pulse_restart();
    mode = 2'b10;
    for (int i = 1; i <= 30; i++) begin
      tick(0);
      check_eq("os_idx", {28'h0, frame_idx}, 32'((i / 6) > 3 ? 3 : (i / 6)));
      check_eq("os_done", {31'h0, done}, 32'(i >= 24));
    end
    pulse_restart();
    check_eq("os_rst_done", {31'h0, done}, 32'd0);
    check_eq("os_rst_idx", {28'h0, frame_idx}, 32'd0);

    // Hold mode and play=0 both freeze the sequence.
    mode = 2'b00;
    ticks(12);
    check_eq("hold_pre_idx", {28'h0, frame_idx}, 32'd2);
    mode = 2'b11;
    ticks(12);
    check_eq("hold_idx", {28'h0, frame_idx}, 32'd2);
    mode = 2'b00; play = 1'b0;
    ticks(6);
    check_eq("pause_idx", {28'h0, frame_idx}, 32'd2);
    play = 1'b1;
    ticks(6);
    check_eq("resume_idx", {28'h0, frame_idx}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
